fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage and IF/ID pipeline register for the 16-bit, 8-register pipeline.
//  - Generates the PC and fetches from a variable-latency instruction memory.
//  - Buffers fetched words in a small prefetch FIFO and presents them to decode.
//  - Obeys pc_en / if_id_en from the hazard detection unit and flushes on a taken branch.
//  - Its IF/ID output is the instruction word the hazard unit inspects.
// PARAMETERS
//  PC_W        16       PC / instruction-address width (word addressed)
//  RESET_PC    16'h0000 first fetch address after reset
//  FIFO_DEPTH  2        prefetch entries; power of 2, >=2
// PORTS
//  clk          in   1     clock, all state on rising edge
//  rst          in   1     asynchronous, active-high reset
//  pc_en        in   1     hazard unit: 0 = do not start new fetches, PC frozen
//  if_id_en     in   1     hazard unit: 0 = hold IF/ID register
//  br_taken     in   1     redirect pulse from EX; highest priority
//  br_target    in   PC_W  redirect address, valid with br_taken
//  imem_req     out  1     fetch request, registered
//  imem_addr    out  PC_W  fetch address, stable while imem_req=1
//  imem_ack     in   1     memory completes the request; data valid this cycle
//  imem_rdata   in   16    instruction word, valid when imem_req & imem_ack
//  if_id_inst   out  16    instruction to decode / HDU; 16'h0000 = NOP bubble
//  if_id_pc1    out  PC_W  address of if_id_inst + 1
//  if_id_valid  out  1     if_id_inst is a real fetched instruction
// BEHAVIOUR
//  Reset (async, immediate):
//   - Outputs: imem_req=0, imem_addr=RESET_PC, if_id_inst=0, if_id_pc1=0, if_id_valid=0.
//   - Internal: fetch_pc=RESET_PC, FIFO empty, FSM=IDLE.
//   - An ack arriving after reset with no request raised is ignored.
//  FSM IDLE/REQ/DROP:
//   - IDLE -> REQ when pc_en & count<FIFO_DEPTH & !br_taken.
//     Set imem_addr=fetch_pc and imem_req=1.
//   - REQ, ack & !br_taken:
//     Push {rdata, imem_addr+1}; fetch_pc+=1.
//     Stay REQ at the new address if pc_en and post-edge count<FIFO_DEPTH; else IDLE.
//   - REQ, br_taken & ack: drop the data -> IDLE.
//   - REQ, br_taken & !ack: -> DROP.
//   - DROP: imem_req stays 1 with the old address until ack; data discarded -> IDLE.
//  Request rules:
//   - A raised request is never withdrawn or re-addressed before ack, regardless of pc_en or br_taken.
//   - Exactly one request is outstanding at a time.
//  Branch (br_taken=1) takes effect at the edge:
//   - fetch_pc=br_target; FIFO cleared.
//   - if_id_inst=0, if_id_valid=0, irrespective of if_id_en.
//   - A second branch during DROP only updates fetch_pc.
//  IF/ID register (no branch):
//   - if_id_en=1 & FIFO non-empty: pop -> if_id_inst / if_id_pc1, valid=1.
//   - if_id_en=1 & FIFO empty: inst=0, valid=0, pc1 held.
//   - if_id_en=0: all three held; FIFO not popped.
//  Latency and count:
//   - No FIFO bypass: the word acked at edge N reaches IF/ID at edge N+1 at the earliest.
//   - Simultaneous push and pop leaves count unchanged, also when full; count never exceeds FIFO_DEPTH.
//  pc_en=0 only stops new requests. Fill and drain of the FIFO continue.
//  PC arithmetic is modulo 2^PC_W: 16'hFFFF+1 wraps to 0.
// TESTING
//  1. Zero-wait memory (ack whenever req), pc_en=if_id_en=1, mem[i]=16'h1000+i
//     -> if_id_pc1 1,2,3,... on consecutive cycles; inst matches; no gaps after first valid.
//  2. if_id_en=0 and pc_en=0 for 4 cycles mid-stream
//     -> IF/ID holds, FIFO fills to 2, imem_req drops; on release every word appears exactly once, in order.
//  3. 3-cycle memory latency, br_taken with br_target=16'h0040 one cycle after req
//     -> imem_addr held until ack, data dropped; next imem_addr=16'h0040; first valid inst=mem[16'h40].
//  4. br_taken while if_id_en=0
//     -> next edge if_id_valid=0, if_id_inst=16'h0000; FIFO empty.
//  5. rst pulsed while in REQ
//     -> imem_req=0 without a clock edge; restart at RESET_PC; no stale word reaches IF/ID.
//  6. fetch_pc=16'hFFFF
//     -> next fetch address 16'h0000, if_id_pc1=16'h0000 for that word.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and instruction memory.
// Exactly one request is outstanding at a time; the address holds steady until it is acknowledged.
interface fetch_unit_if #(
  parameter int PC_W = 16
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [15:0]     imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage with prefetch FIFO and IF/ID pipeline register.
// A request that has been raised is always allowed to complete; a branch only decides whether its data is kept.
module fetch_unit #(
  parameter int              PC_W       = 16,
  parameter logic [PC_W-1:0] RESET_PC   = 16'h0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pc_en,
  input  logic             if_id_en,
  input  logic             br_taken,
  input  logic [PC_W-1:0]  br_target,
  fetch_unit_if.master     imem,
  output logic [15:0]      if_id_inst,
  output logic [PC_W-1:0]  if_id_pc1,
  output logic             if_id_valid
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  logic [1:0]      state_r, state_nxt_s;
  logic            imem_req_r, req_nxt_s;
  logic [PC_W-1:0] imem_addr_r, addr_nxt_s;
  logic [PC_W-1:0] fetch_pc_r, pc_nxt_s;
  logic [PC_W-1:0] addr_inc_s;
  logic [15:0]     fifo_inst_r [FIFO_DEPTH];
  logic [PC_W-1:0] fifo_pc1_r  [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0] count_r, count_post_s;
  logic            push_s, pop_s;

  assign imem.imem_req  = imem_req_r;
  assign imem.imem_addr = imem_addr_r;

  // Wraps modulo 2^PC_W, so the word at 16'hFFFF carries pc1 = 0.
  assign addr_inc_s   = imem_addr_r + PC_W'(1'b1);
  assign push_s       = (state_r == ST_REQ) && imem.imem_ack && !br_taken;
  assign pop_s        = !br_taken && if_id_en && (count_r != CNT_ZERO);
  assign count_post_s = count_r + CNT_W'(push_s) - CNT_W'(pop_s);

  // Request FSM next-state: IDLE issues, REQ streams, DROP waits out a killed request.
  always_comb begin
    state_nxt_s = state_r;
    req_nxt_s   = imem_req_r;
    addr_nxt_s  = imem_addr_r;
    pc_nxt_s    = fetch_pc_r;
    case (state_r)
      ST_IDLE: begin
        if (pc_en && !br_taken && (count_r < DEPTH_C)) begin
          state_nxt_s = ST_REQ;
          req_nxt_s   = 1'b1;
          addr_nxt_s  = fetch_pc_r;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (imem.imem_ack && br_taken) begin
          state_nxt_s = ST_IDLE;
          req_nxt_s   = 1'b0;
        end else if (imem.imem_ack) begin
          pc_nxt_s = addr_inc_s;
          if (pc_en && (count_post_s < DEPTH_C)) begin
            addr_nxt_s = addr_inc_s;
          end else begin
            state_nxt_s = ST_IDLE;
            req_nxt_s   = 1'b0;
          end
        end else if (br_taken) begin
          state_nxt_s = ST_DROP;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_DROP: begin
        if (imem.imem_ack) begin
          state_nxt_s = ST_IDLE;
          req_nxt_s   = 1'b0;
        end else begin
          state_nxt_s = ST_DROP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        req_nxt_s   = 1'b0;
      end
    endcase
    if (br_taken) begin
      pc_nxt_s = br_target;
    end else begin
      pc_nxt_s = pc_nxt_s;
    end
  end

  // FSM, fetch PC and registered memory request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      imem_req_r  <= 1'b0;
      imem_addr_r <= RESET_PC;
      fetch_pc_r  <= RESET_PC;
    end else begin
      state_r     <= state_nxt_s;
      imem_req_r  <= req_nxt_s;
      imem_addr_r <= addr_nxt_s;
      fetch_pc_r  <= pc_nxt_s;
    end
  end

  // Prefetch FIFO storage and occupancy; a branch empties it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_inst_r[i] <= 16'h0000;
        fifo_pc1_r[i]  <= {PC_W{1'b0}};
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= CNT_ZERO;
    end else if (br_taken) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= CNT_ZERO;
    end else begin
      if (push_s) begin
        fifo_inst_r[wr_ptr_r] <= imem.imem_rdata;
        fifo_pc1_r[wr_ptr_r]  <= addr_inc_s;
        wr_ptr_r              <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
      count_r <= count_post_s;
    end
  end

  // IF/ID register: pops only from the registered FIFO, so fetched data never bypasses it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_id_inst  <= 16'h0000;
      if_id_pc1   <= {PC_W{1'b0}};
      if_id_valid <= 1'b0;
    end else if (br_taken) begin
      if_id_inst  <= 16'h0000;
      if_id_valid <= 1'b0;
    end else if (if_id_en) begin
      if (count_r != CNT_ZERO) begin
        if_id_inst  <= fifo_inst_r[rd_ptr_r];
        if_id_pc1   <= fifo_pc1_r[rd_ptr_r];
        if_id_valid <= 1'b1;
      end else begin
        if_id_inst  <= 16'h0000;
        if_id_valid <= 1'b0;
      end
    end
  end

endmodule
